// File: rtl/core_pkg.sv
// core_pkg: constants and fetch-state encoding shared by fetch, decode and
// immediate generation.
package core_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  LOAD      = 7'b0000011;
    localparam logic [6:0]  STORE     = 7'b0100011;
    localparam logic [6:0]  BRANCH    = 7'b1100011;
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} fetch_state_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry {pc, instr} buffer that catches a word acked while
// decode is stalled; clear takes priority over load.
module fetch_skid_buf (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        i_load,
    input  logic        i_clear,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instr,
    output logic        o_full,
    output logic [31:0] o_pc,
    output logic [31:0] o_instr
);
    logic        r_full;
    logic [31:0] r_pc;
    logic [31:0] r_instr;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_full  <= 1'b0;
            r_pc    <= '0;
            r_instr <= '0;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_full  <= 1'b1;
            r_pc    <= i_pc;
            r_instr <= i_instr;
        end
    end

    assign o_full  = r_full;
    assign o_pc    = r_pc;
    assign o_instr = r_instr;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner, instruction-memory requester and IF/ID register
// with stall skid buffering, branch redirect and in-flight request discard.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        valid_o
);
    import core_pkg::*;

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_disc_addr;
    logic [31:0]  r_if_pc;
    logic [31:0]  r_if_instr;
    logic         r_if_valid;
    logic         w_req;
    logic [31:0]  w_target;
    logic         w_skid_load;
    logic         w_skid_clear;
    logic         w_skid_full;
    logic [31:0]  w_skid_pc;
    logic [31:0]  w_skid_instr;

    assign w_req        = (r_state == FETCH) || (r_state == DISCARD);
    assign w_target     = branch_target_i & ~32'h3;
    assign w_skid_load  = (r_state == FETCH) && imem_ack_i && stall_i && !branch_taken_i;
    assign w_skid_clear = ((r_state != IDLE) && branch_taken_i) || ((r_state == HOLD) && !stall_i);

    fetch_skid_buf u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_pc    (r_pc),
        .i_instr (imem_data_i),
        .o_full  (w_skid_full),
        .o_pc    (w_skid_pc),
        .o_instr (w_skid_instr)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= IDLE;
            r_pc        <= RESET_PC;
            r_disc_addr <= RESET_PC;
            r_if_pc     <= '0;
            r_if_instr  <= NOP_INSTR;
            r_if_valid  <= 1'b0;
        end else if (r_state == IDLE) begin
            if (start_i) r_state <= FETCH;
        end else if (branch_taken_i) begin
            // A request already on the bus must still complete at its old address
            r_if_valid <= 1'b0;
            r_if_instr <= NOP_INSTR;
            r_pc       <= w_target;
            r_state    <= (w_req && !imem_ack_i) ? DISCARD : FETCH;
            if (r_state == FETCH) r_disc_addr <= r_pc;
        end else begin
            case (r_state)
                FETCH: begin
                    if (imem_ack_i) begin
                        r_pc <= r_pc + 32'd4;
                        if (stall_i) begin
                            r_state <= HOLD;
                        end else begin
                            r_if_pc    <= r_pc;
                            r_if_instr <= imem_data_i;
                            r_if_valid <= 1'b1;
                        end
                    end else if (!stall_i) begin
                        r_if_instr <= NOP_INSTR;
                        r_if_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall_i) begin
                        r_if_pc    <= w_skid_pc;
                        r_if_instr <= w_skid_instr;
                        r_if_valid <= w_skid_full;
                        r_state    <= FETCH;
                    end
                end
                DISCARD: if (imem_ack_i) r_state <= FETCH;
                default: ;
            endcase
        end
    end

    assign imem_req_o  = w_req;
    assign imem_addr_o = (r_state == DISCARD) ? r_disc_addr : r_pc;
    assign pc_o        = r_if_pc;
    assign instr_o     = r_if_instr;
    assign valid_o     = r_if_valid;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed stimulus pushes expected IF/ID words into a
// queue; a monitor pops and compares each newly presented instruction.
module tb_instr_fetch_unit;
    localparam logic [31:0] K   = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        branch_taken_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
    logic        valid_o;
    logic        ack_en = 1'b0;

    int total = 0;
    int bad = 0;
    logic [63:0] sb[$];

    instr_fetch_unit dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .stall_i         (stall_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ack_i      (imem_ack_i),
        .imem_data_i     (imem_data_i),
        .pc_o            (pc_o),
        .instr_o         (instr_o),
        .valid_o         (valid_o)
    );

    always #5 clk_i = ~clk_i;

    assign imem_ack_i  = imem_req_o & ack_en;
    assign imem_data_i = imem_addr_o ^ K;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk_i);
    endtask

    task automatic fetch_ok(input logic [31:0] a);
        chk("req", {31'd0, imem_req_o}, 32'd1);
        chk("addr", imem_addr_o, a);
        sb.push_back({a, a ^ K});
        cyc();
    endtask

    task automatic chk_reset();
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_instr", instr_o, NOP);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_req", {31'd0, imem_req_o}, 32'd0);
        chk("rst_addr", imem_addr_o, 32'h0);
    endtask

    // A new IF/ID word appears when valid is high and no stall held the register
    initial begin
        logic st;
        logic [63:0] e;
        forever begin
            @(posedge clk_i);
            st = stall_i;
            #1;
            if (rst_i && valid_o && !st) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_pc", pc_o, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("sb_pc", pc_o, e[63:32]);
                    chk("sb_instr", instr_o, e[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) cyc();
        chk_reset();
        rst_i = 1'b1;
        start_i = 1'b1;
        ack_en = 1'b1;
        cyc();
        for (int i = 0; i < 4; i++) fetch_ok(32'(i * 4));
        chk("pipe_valid", {31'd0, valid_o}, 32'd1);
        // restart, then delayed ack at 8 and a stall at 0x10
        rst_i = 1'b0;
        cyc();
        rst_i = 1'b1;
        cyc();
        fetch_ok(32'h0);
        fetch_ok(32'h4);
        ack_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("delay_req", {31'd0, imem_req_o}, 32'd1);
            chk("delay_addr", imem_addr_o, 32'h8);
            cyc();
        end
        chk("delay_bubble", {31'd0, valid_o}, 32'd0);
        ack_en = 1'b1;
        fetch_ok(32'h8);
        fetch_ok(32'hC);
        stall_i = 1'b1;
        fetch_ok(32'h10);
        chk("stall_pc", pc_o, 32'hC);
        chk("stall_instr", instr_o, 32'hC ^ K);
        chk("hold_req", {31'd0, imem_req_o}, 32'd0);
        cyc();
        chk("stall2_instr", instr_o, 32'hC ^ K);
        stall_i = 1'b0;
        cyc();
        chk("release_instr", instr_o, 32'h10 ^ K);
        fetch_ok(32'h14);
        fetch_ok(32'h18);
        fetch_ok(32'h1C);
        // redirect while 0x20 is outstanding
        ack_en = 1'b0;
        chk("pend_addr", imem_addr_o, 32'h20);
        cyc();
        branch_taken_i = 1'b1;
        branch_target_i = 32'h103;
        cyc();
        branch_taken_i = 1'b0;
        chk("flush_valid", {31'd0, valid_o}, 32'd0);
        chk("flush_instr", instr_o, NOP);
        chk("flush_pc", pc_o, 32'h1C);
        chk("disc_req", {31'd0, imem_req_o}, 32'd1);
        chk("disc_addr", imem_addr_o, 32'h20);
        ack_en = 1'b1;
        cyc();
        chk("drop_valid", {31'd0, valid_o}, 32'd0);
        fetch_ok(32'h100);
        fetch_ok(32'h104);
        // branch and stall together: branch wins
        chk("bs_addr", imem_addr_o, 32'h108);
        stall_i = 1'b1;
        branch_taken_i = 1'b1;
        branch_target_i = 32'h40;
        cyc();
        stall_i = 1'b0;
        branch_taken_i = 1'b0;
        chk("bs_valid", {31'd0, valid_o}, 32'd0);
        fetch_ok(32'h40);
        // async reset with skid buffer full
        stall_i = 1'b1;
        chk("skid_addr", imem_addr_o, 32'h44);
        cyc();
        chk("skid_hold_req", {31'd0, imem_req_o}, 32'd0);
        #2 rst_i = 1'b0;
        #1 chk_reset();
        cyc();
        stall_i = 1'b0;
        rst_i = 1'b1;
        cyc();
        fetch_ok(32'h0);
        fetch_ok(32'h4);
        ack_en = 1'b0;
        repeat (2) cyc();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage RV32I core.
- Owns the PC and issues requests to instruction memory over a req/ack handshake.
- Applies branch redirects, hazard stalls and flushes.
- Presents {pc, instr, valid} to the decode stage, where the immediate generator and register file consume instr_o.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, encoding driven into the IF/ID slot when empty or flushed (addi x0,x0,0).

Ports:
- clk_i  input  1  core clock; all state updates on rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- start_i  input  1  level; fetching begins on the first cycle it is seen high after reset.
- stall_i  input  1  hazard unit: hold IF/ID contents and PC.
- branch_taken_i  input  1  EX-stage redirect; also flushes IF/ID.
- branch_target_i  input  32  redirect PC; bits [1:0] are ignored and forced to 0.
- imem_req_o  output  1  instruction memory request.
- imem_addr_o  output  32  request address; word aligned.
- imem_ack_i  input  1  memory returns data this cycle; may be high in the same cycle as req.
- imem_data_i  input  32  instruction word; valid when imem_ack_i=1.
- pc_o  output  32  IF/ID PC.
- instr_o  output  32  IF/ID instruction.
- valid_o  output  1  IF/ID slot holds a real instruction.

Behaviour:
- Reset (rst_i low, asynchronous):
  - state=IDLE, pc_q=RESET_PC, imem_req_o=0, imem_addr_o=RESET_PC.
  - pc_o=0, instr_o=NOP_INSTR, valid_o=0.
  - skid buffer empty, redirect_pending=0.
- States:
  - IDLE: imem_req_o=0. start_i=1 -> FETCH.
  - FETCH: imem_req_o=1, imem_addr_o=pc_q.
  - HOLD: skid buffer full; no request issued.
  - DISCARD: outstanding request must complete; its data is dropped.
- Handshake rule: once imem_req_o=1, imem_addr_o and imem_req_o stay stable until the cycle imem_ack_i=1. The request is never withdrawn, including on redirect.
- FETCH, ack, no stall, no branch:
  - IF/ID <= {pc_q, imem_data_i, 1}; pc_q <= pc_q+4.
  - Stays in FETCH.
  - Data acked in cycle N appears on instr_o in cycle N+1.
  - Throughput: 1 instruction/cycle when ack is combinational.
- FETCH, ack, stall_i=1:
  - IF/ID holds.
  - {pc_q, imem_data_i} captured in skid buffer; pc_q <= pc_q+4.
  - -> HOLD.
- FETCH, no ack, stall_i=1: IF/ID holds, request continues.
- HOLD:
  - While stall_i=1: everything holds.
  - When stall_i=0: IF/ID <= skid entry with valid=1; buffer empties; -> FETCH.
- Redirect (branch_taken_i=1, any state except IDLE):
  - Next cycle: valid_o=0, instr_o=NOP_INSTR, pc_o holds its previous value.
  - Skid buffer cleared; pc_q <= {branch_target_i[31:2], 2'b00}.
  - In FETCH with no ack this cycle: -> DISCARD.
  - Otherwise -> FETCH; the new address is issued next cycle.
  - Any data acked in the redirect cycle is dropped.
- DISCARD:
  - Request held at the old address until ack; data dropped.
  - -> FETCH with addr=pc_q (the target).
  - A second branch_taken_i while in DISCARD overwrites pc_q with the newer target.
- Simultaneous branch_taken_i and stall_i: branch wins. Flush and redirect occur, and the stall is ignored for that cycle.
- PC arithmetic: 32-bit, wraps 32'hFFFF_FFFC -> 32'h0000_0000 silently.
- start_i deasserted after leaving IDLE: ignored; there is no return to IDLE except via reset.
- Reset asserted mid-transaction: immediate return to reset values. The pending memory access is abandoned; the memory side must tolerate req dropping on reset.

Decomposition:
- Shared package core_pkg:
  - NOP_INSTR.
  - RV32I opcode constants (OP_IMM 7'b0010011, LOAD 7'b0000011, STORE 7'b0100011, BRANCH 7'b1100011), shared with decode and immediate generation.
  - fetch state enum {IDLE, FETCH, HOLD, DISCARD}.
- One natural sub-module: fetch_skid_buf, a one-entry {pc, instr} buffer with load/clear/full.

Test Plan:
- Reset, start_i=1, ack every cycle, memory returns addr^32'hA5A5_0000 -> imem_addr_o 0,4,8,C on consecutive cycles; instr_o matches one cycle later with valid_o=1.
- Ack delayed 3 cycles at addr 8 -> imem_req_o and imem_addr_o=8 stable for 4 cycles; no duplicate or skipped instruction.
- stall_i high for 2 cycles while acking addr 0x10 -> IF/ID holds 0x0C; on release instr_o shows the 0x10 word, then 0x14 is fetched; no loss or duplication.
- branch_taken_i with target 0x103 while the request at 0x20 is un-acked -> valid_o=0 and instr_o=NOP next cycle; 0x20 data dropped on ack; next request at 0x100.
- branch_taken_i and stall_i high in the same cycle, target 0x40 -> flush occurs, next imem_addr_o=0x40.
- rst_i low mid-stall with skid buffer full -> all outputs return to reset values asynchronously; after release plus start_i, fetch restarts at RESET_PC.
